// File: rtl/commit_phase_tracker_if.sv
// Event stream from the phase tracker to its consumer: one timestamped marker per transfer,
// accepted on evt_valid && evt_ready.
interface commit_phase_tracker_if #(
    parameter int unsigned CNT_W = 32
);
    logic             evt_valid;
    logic             evt_ready;
    logic [4:0]       evt_phase;
    logic             evt_is_end;
    logic [2:0]       evt_lane;
    logic [CNT_W-1:0] evt_time;

    modport master (
        output evt_valid,
        output evt_phase,
        output evt_is_end,
        output evt_lane,
        output evt_time,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_phase,
        input  evt_is_end,
        input  evt_lane,
        input  evt_time,
        output evt_ready
    );
endinterface

// File: rtl/commit_phase_tracker.sv
// Watches the commit lanes for slti x0,x0,imm phase markers and keeps per-phase active, length and
// error state, plus a FIFO of timestamped marker events for a ready/valid consumer.
module commit_phase_tracker #(
    parameter int unsigned COMMIT_W   = 2,
    parameter int unsigned NUM_PHASES = 7,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [COMMIT_W-1:0]    commit_valid,
    input  logic [32*COMMIT_W-1:0] commit_inst,
    commit_phase_tracker_if.master evt,
    output logic [NUM_PHASES-1:0]  phase_active,
    output logic [NUM_PHASES-1:0]  phase_error,
    input  logic [4:0]             len_sel,
    output logic [CNT_W-1:0]       len_out,
    output logic [15:0]            drop_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic {StIdle, StActive} phase_state_e;

    typedef struct packed {
        logic [4:0]       phase;
        logic             is_end;
        logic [2:0]       lane;
        logic [CNT_W-1:0] stamp;
    } evt_t;

    logic [COMMIT_W-1:0] lane_mark;
    logic [COMMIT_W-1:0] lane_end;
    logic [4:0]          lane_phase [COMMIT_W];

    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            lane_mark[i]  = commit_valid[i]
                            && (commit_inst[32*i +: 20] == 20'h02013)
                            && (commit_inst[32*i+20 +: 12] < 12'(2 * NUM_PHASES));
            lane_end[i]   = commit_inst[32*i+20];
            lane_phase[i] = commit_inst[32*i+21 +: 5];
        end
    end

    phase_state_e          state_q [NUM_PHASES];
    phase_state_e          state_d [NUM_PHASES];
    logic [CNT_W-1:0]      run_q   [NUM_PHASES];
    logic [CNT_W-1:0]      run_d   [NUM_PHASES];
    logic [CNT_W-1:0]      len_q   [NUM_PHASES];
    logic [CNT_W-1:0]      len_d   [NUM_PHASES];
    logic [NUM_PHASES-1:0] err_q;
    logic [NUM_PHASES-1:0] err_d;

    // run_d starts as the value the counter reaches at this edge, so an END latches the
    // full START-edge to END-edge distance and a same-cycle START/END latches 0.
    always_comb begin
        err_d = err_q;
        for (int p = 0; p < NUM_PHASES; p++) begin
            state_d[p] = state_q[p];
            len_d[p]   = len_q[p];
            run_d[p]   = (state_q[p] == StActive && run_q[p] != '1) ? run_q[p] + CNT_W'(1)
                                                                     : run_q[p];
        end
        for (int i = 0; i < COMMIT_W; i++) begin
            for (int p = 0; p < NUM_PHASES; p++) begin
                if (lane_mark[i] && lane_phase[i] == 5'(p)) begin
                    if (!lane_end[i]) begin
                        if (state_d[p] == StActive) err_d[p] = 1'b1;
                        state_d[p] = StActive;
                        run_d[p]   = '0;
                    end else if (state_d[p] == StActive) begin
                        len_d[p]   = run_d[p];
                        state_d[p] = StIdle;
                    end else begin
                        err_d[p] = 1'b1;
                    end
                end
            end
        end
    end

    evt_t                mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_q;
    logic [AW-1:0]       rd_q;
    logic [AW:0]         count_q;
    logic [AW:0]         count_d;
    logic [AW:0]         cap;
    logic [AW-1:0]       slot [COMMIT_W];
    logic [COMMIT_W-1:0] do_push;
    logic                pop;
    logic [15:0]         drop_q;
    logic [15:0]         drop_d;
    logic [16:0]         drop_sum;
    logic [CNT_W-1:0]    ts_q;
    int unsigned         n_mark;
    int unsigned         n_push;

    // Markers take consecutive slots in lane order; anything past capacity is dropped, which
    // naturally drops the highest lanes first.
    always_comb begin
        pop    = (count_q != '0) && evt.evt_ready;
        cap    = (AW+1)'(FIFO_DEPTH) - count_q + (AW+1)'(pop);
        n_mark = 0;
        n_push = 0;
        for (int i = 0; i < COMMIT_W; i++) begin
            slot[i]    = wr_q + AW'(n_mark);
            do_push[i] = lane_mark[i] && (n_mark < 32'(cap));
            if (lane_mark[i]) n_mark = n_mark + 1;
            if (do_push[i]) n_push = n_push + 1;
        end
        count_d  = count_q + (AW+1)'(n_push) - (AW+1)'(pop);
        drop_sum = {1'b0, drop_q} + 17'(n_mark - n_push);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            drop_q  <= '0;
            err_q   <= '0;
            for (int p = 0; p < NUM_PHASES; p++) begin
                state_q[p] <= StIdle;
                run_q[p]   <= '0;
                len_q[p]   <= '0;
            end
        end else begin
            ts_q    <= ts_q + CNT_W'(1);
            wr_q    <= wr_q + AW'(n_push);
            rd_q    <= rd_q + AW'(pop);
            count_q <= count_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            for (int p = 0; p < NUM_PHASES; p++) begin
                state_q[p] <= state_d[p];
                run_q[p]   <= run_d[p];
                len_q[p]   <= len_d[p];
            end
        end
    end

    // Storage needs no reset: entries are only visible behind count_q.
    always_ff @(posedge clock) begin
        for (int i = 0; i < COMMIT_W; i++) begin
            if (do_push[i]) begin
                mem[slot[i]] <= '{phase: lane_phase[i], is_end: lane_end[i], lane: 3'(i),
                                  stamp: ts_q};
            end
        end
    end

    always_comb begin
        len_out = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            phase_active[p] = (state_q[p] == StActive);
            if (len_sel == 5'(p)) len_out = len_q[p];
        end
    end

    assign phase_error    = err_q;
    assign drop_count     = drop_q;
    assign evt.evt_valid  = (count_q != '0);
    assign evt.evt_phase  = mem[rd_q].phase;
    assign evt.evt_is_end = mem[rd_q].is_end;
    assign evt.evt_lane   = mem[rd_q].lane;
    assign evt.evt_time   = mem[rd_q].stamp;
endmodule

// File: tb/tb_commit_phase_tracker.sv
// Directed bench for commit_phase_tracker: phase FSM, lengths, errors, FIFO ordering,
// overflow, backpressure and mid-run reset.
module tb_commit_phase_tracker;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [4:0]  phase;
        logic        is_end;
        logic [2:0]  lane;
        logic [31:0] stamp;
    } ev_t;

    logic        clock;
    logic        reset;
    logic [1:0]  commit_valid;
    logic [63:0] commit_inst;
    logic [6:0]  phase_active;
    logic [6:0]  phase_error;
    logic [4:0]  len_sel;
    logic [31:0] len_out;
    logic [15:0] drop_count;
    logic [31:0] tb_ts;
    int          total = 0;
    int          bad   = 0;

    commit_phase_tracker_if #(.CNT_W(32)) evt_if ();

    commit_phase_tracker #(
        .COMMIT_W   (2),
        .NUM_PHASES (7),
        .CNT_W      (32),
        .FIFO_DEPTH (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_inst  (commit_inst),
        .evt          (evt_if),
        .phase_active (phase_active),
        .phase_error  (phase_error),
        .len_sel      (len_sel),
        .len_out      (len_out),
        .drop_count   (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected timestamp: 0 in the cycle after reset, +1 per cycle.
    always @(posedge clock) begin
        if (reset) tb_ts <= 32'd0;
        else tb_ts <= tb_ts + 32'd1;
    end

    function automatic logic [31:0] mk(input int unsigned imm);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 20'h02013};
    endfunction

    function automatic ev_t head();
        return {evt_if.evt_phase, evt_if.evt_is_end, evt_if.evt_lane, evt_if.evt_time};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
        commit_valid = v;
        commit_inst  = {i1, i0};
    endtask

    task automatic read_len(input int sel, output logic [31:0] val);
        len_sel = 5'(sel);
        #1;
        val = len_out;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        evt_if.evt_ready = 1'b0;
        drive(2'b00, NOP, NOP);
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] l;
        do_reset();
        total++; if (evt_if.evt_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b want=0", evt_if.evt_valid); end
        total++; if (phase_active !== 7'd0) begin
            bad++; $display("FAIL reset_active got=%b want=0", phase_active); end
        total++; if (phase_error !== 7'd0) begin
            bad++; $display("FAIL reset_error got=%b want=0", phase_error); end
        total++; if (drop_count !== 16'd0) begin
            bad++; $display("FAIL reset_drop got=%0d want=0", drop_count); end
        read_len(0, l);
        total++; if (l !== 32'd0) begin
            bad++; $display("FAIL reset_len got=%0d want=0", l); end
    endtask

    task automatic test_single_lane();
        logic [31:0] l;
        ev_t         want;
        do_reset();
        repeat (10) step();
        // Lane 1 carries imm 14, one past the last phase: must be ignored.
        drive(2'b11, 32'h0000_2013, 32'h00e0_2013);
        step();
        drive(2'b00, NOP, NOP);
        want = {5'd0, 1'b0, 3'd0, 32'd10};
        total++; if (!evt_if.evt_valid || head() !== want) begin
            bad++; $display("FAIL single_start_evt got=%h v=%b want=%h", head(),
                            evt_if.evt_valid, want); end
        for (int c = 11; c <= 24; c++) begin
            total++; if (phase_active[0] !== 1'b1) begin
                bad++; $display("FAIL single_active cyc=%0d got=0 want=1", c); end
            step();
        end
        total++; if (phase_active[0] !== 1'b1) begin
            bad++; $display("FAIL single_active cyc=25 got=0 want=1"); end
        drive(2'b01, 32'h0010_2013, NOP);
        step();
        drive(2'b00, NOP, NOP);
        total++; if (phase_active !== 7'd0) begin
            bad++; $display("FAIL single_idle got=%b want=0", phase_active); end
        read_len(0, l);
        total++; if (l !== 32'd15) begin
            bad++; $display("FAIL single_len got=%0d want=15", l); end
        read_len(7, l);
        total++; if (l !== 32'd0) begin
            bad++; $display("FAIL len_sel7 got=%0d want=0", l); end
        read_len(31, l);
        total++; if (l !== 32'd0) begin
            bad++; $display("FAIL len_sel31 got=%0d want=0", l); end
        evt_if.evt_ready = 1'b1;
        step();
        want = {5'd0, 1'b1, 3'd0, 32'd25};
        total++; if (!evt_if.evt_valid || head() !== want) begin
            bad++; $display("FAIL single_end_evt got=%h v=%b want=%h", head(),
                            evt_if.evt_valid, want); end
        step();
        total++; if (evt_if.evt_valid !== 1'b0) begin
            bad++; $display("FAIL single_drained got=%b want=0", evt_if.evt_valid); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_same_cycle();
        logic [31:0] l;
        logic [31:0] t;
        ev_t         want;
        do_reset();
        evt_if.evt_ready = 1'b1;
        drive(2'b01, mk(4), NOP);
        step();
        drive(2'b00, NOP, NOP);
        step();
        step();
        drive(2'b01, mk(5), NOP);
        step();
        drive(2'b00, NOP, NOP);
        read_len(2, l);
        total++; if (l !== 32'd3) begin
            bad++; $display("FAIL pre_len got=%0d want=3", l); end
        step();
        step();
        total++; if (evt_if.evt_valid !== 1'b0) begin
            bad++; $display("FAIL pre_drain got=%b want=0", evt_if.evt_valid); end
        evt_if.evt_ready = 1'b0;
        t = tb_ts;
        drive(2'b11, mk(4), mk(5));
        step();
        drive(2'b00, NOP, NOP);
        read_len(2, l);
        total++; if (l !== 32'd0) begin
            bad++; $display("FAIL pair_len got=%0d want=0", l); end
        total++; if (phase_active !== 7'd0 || phase_error !== 7'd0) begin
            bad++; $display("FAIL pair_state act=%b err=%b want=0/0", phase_active,
                            phase_error); end
        want = {5'd2, 1'b0, 3'd0, t};
        total++; if (!evt_if.evt_valid || head() !== want) begin
            bad++; $display("FAIL pair_evt0 got=%h want=%h", head(), want); end
        evt_if.evt_ready = 1'b1;
        step();
        want = {5'd2, 1'b1, 3'd1, t};
        total++; if (!evt_if.evt_valid || head() !== want) begin
            bad++; $display("FAIL pair_evt1 got=%h want=%h", head(), want); end
        // END on lane 0 closes phase 4, START on lane 1 reopens it.
        drive(2'b01, mk(8), NOP);
        step();
        drive(2'b00, NOP, NOP);
        step();
        drive(2'b11, mk(9), mk(8));
        step();
        drive(2'b00, NOP, NOP);
        read_len(4, l);
        total++; if (l !== 32'd2) begin
            bad++; $display("FAIL reopen_len got=%0d want=2", l); end
        total++; if (phase_active !== 7'b0010000 || phase_error !== 7'd0) begin
            bad++; $display("FAIL reopen_state act=%b err=%b want=0010000/0", phase_active,
                            phase_error); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_protocol_errors();
        logic [31:0] l;
        do_reset();
        drive(2'b01, 32'h0030_2013, NOP);
        step();
        drive(2'b00, NOP, NOP);
        read_len(1, l);
        total++; if (phase_error !== 7'b0000010 || phase_active !== 7'd0 || l !== 32'd0) begin
            bad++; $display("FAIL end_idle err=%b act=%b len=%0d want=0000010/0/0",
                            phase_error, phase_active, l); end
        drive(2'b01, 32'h00c0_2013, NOP);
        step();
        drive(2'b00, NOP, NOP);
        repeat (4) step();
        total++; if (phase_active[6] !== 1'b1 || phase_error !== 7'b0000010) begin
            bad++; $display("FAIL first_start act=%b err=%b", phase_active, phase_error); end
        drive(2'b01, 32'h00c0_2013, NOP);
        step();
        drive(2'b00, NOP, NOP);
        total++; if (phase_active[6] !== 1'b1 || phase_error !== 7'b1000010) begin
            bad++; $display("FAIL double_start act=%b err=%b want err=1000010", phase_active,
                            phase_error); end
        step();
        step();
        drive(2'b01, 32'h00d0_2013, NOP);
        step();
        drive(2'b00, NOP, NOP);
        read_len(6, l);
        total++; if (l !== 32'd3 || phase_active !== 7'd0) begin
            bad++; $display("FAIL restart_len len=%0d act=%b want=3/0", l, phase_active); end
    endtask

    task automatic test_overflow();
        ev_t want;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(2'b11, mk(2 * (k % 7)), mk(2 * (k % 7) + 1));
            step();
        end
        drive(2'b00, NOP, NOP);
        total++; if (drop_count !== 16'd2 || evt_if.evt_valid !== 1'b1) begin
            bad++; $display("FAIL ovf_drop got=%0d v=%b want=2/1", drop_count,
                            evt_if.evt_valid); end
        evt_if.evt_ready = 1'b1;
        for (int e = 0; e < 16; e++) begin
            want = {5'((e / 2) % 7), 1'(e % 2), 3'(e % 2), 32'(e / 2)};
            total++; if (!evt_if.evt_valid || head() !== want) begin
                bad++; $display("FAIL ovf_entry%0d got=%h v=%b want=%h", e, head(),
                                evt_if.evt_valid, want); end
            step();
        end
        total++; if (evt_if.evt_valid !== 1'b0) begin
            bad++; $display("FAIL ovf_count got=%b want=0 after 16", evt_if.evt_valid); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        ev_t         q[$];
        ev_t         held;
        ev_t         want;
        logic        stalled;
        int          issued;
        int unsigned lane;
        int unsigned ph;
        int unsigned en;
        logic [31:0] inst;
        int          cyc;
        do_reset();
        stalled = 1'b0;
        issued  = 0;
        cyc     = 0;
        while ((issued < 100 || q.size() != 0) && cyc < 5000) begin
            evt_if.evt_ready = 1'($urandom_range(0, 1));
            if (stalled) begin
                total++; if (!evt_if.evt_valid || head() !== held) begin
                    bad++; $display("FAIL bp_stable got=%h v=%b want=%h", head(),
                                    evt_if.evt_valid, held); end
            end
            if (evt_if.evt_valid && evt_if.evt_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL bp_extra got=%h want=none", head());
                end else begin
                    want = q.pop_front();
                    if (head() !== want) begin
                        bad++; $display("FAIL bp_order got=%h want=%h", head(), want); end
                end
            end
            stalled = evt_if.evt_valid && !evt_if.evt_ready;
            held    = head();
            if (issued < 100 && q.size() < 12 && $urandom_range(0, 2) == 0) begin
                lane = $urandom_range(0, 1);
                ph   = $urandom_range(0, 6);
                en   = $urandom_range(0, 1);
                inst = mk(2 * ph + en);
                if (lane == 0) drive(2'b01, inst, NOP);
                else drive(2'b10, NOP, inst);
                q.push_back({5'(ph), 1'(en), 3'(lane), tb_ts});
                issued++;
            end else begin
                drive(2'b00, NOP, NOP);
            end
            step();
            cyc++;
        end
        drive(2'b00, NOP, NOP);
        total++; if (q.size() != 0 || issued != 100) begin
            bad++; $display("FAIL bp_timeout left=%0d issued=%0d want=0/100", q.size(),
                            issued); end
        total++; if (drop_count !== 16'd0) begin
            bad++; $display("FAIL bp_drop got=%0d want=0", drop_count); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_reset_mid_phase();
        logic [31:0] l;
        logic        any_len;
        ev_t         want;
        do_reset();
        drive(2'b01, mk(0), NOP);
        step();
        drive(2'b00, NOP, NOP);
        step();
        drive(2'b01, mk(1), NOP);
        step();
        drive(2'b11, mk(6), mk(3));
        step();
        drive(2'b00, NOP, NOP);
        read_len(0, l);
        total++; if (phase_active !== 7'b0001000 || phase_error !== 7'b0000010 ||
                     l !== 32'd2) begin
            bad++; $display("FAIL pre_reset act=%b err=%b len=%0d", phase_active, phase_error,
                            l); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (phase_active !== 7'd0 || phase_error !== 7'd0 ||
                     evt_if.evt_valid !== 1'b0 || drop_count !== 16'd0) begin
            bad++; $display("FAIL mid_reset act=%b err=%b v=%b drop=%0d want all 0",
                            phase_active, phase_error, evt_if.evt_valid, drop_count); end
        any_len = 1'b0;
        for (int p = 0; p < 7; p++) begin
            read_len(p, l);
            if (l !== 32'd0) any_len = 1'b1;
        end
        total++; if (any_len !== 1'b0) begin
            bad++; $display("FAIL mid_reset_len got=nonzero want=0"); end
        drive(2'b01, mk(7), NOP);
        step();
        drive(2'b00, NOP, NOP);
        want = {5'd3, 1'b1, 3'd0, 32'd0};
        total++; if (phase_error !== 7'b0001000 || !evt_if.evt_valid || head() !== want) begin
            bad++; $display("FAIL post_reset_end err=%b evt=%h want=0001000/%h", phase_error,
                            head(), want); end
    endtask

    initial begin
        reset            = 1'b1;
        evt_if.evt_ready = 1'b0;
        len_sel          = 5'd0;
        commit_valid     = 2'b00;
        commit_inst      = {NOP, NOP};
        test_reset();
        test_single_lane();
        test_same_cycle();
        test_protocol_errors();
        test_overflow();
        test_backpressure();
        test_reset_mid_phase();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
